// File: rtl/rans_pkg.sv
// Shared types for the rANS byte packer.
// Word/keep widths and the FIFO entry layout.
package rans_pkg;

  localparam int SYM_W  = 8;
  localparam int NLANES = 4;
  localparam int WORD_W = SYM_W * NLANES;
  localparam int KEEP_W = NLANES;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } word_t;

endpackage

// File: rtl/rans_word_fifo.sv
// First-word-fall-through FIFO of packed words.
// Head reads zero whenever the FIFO is empty.
module rans_word_fifo
  import rans_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  word_t       din_i,
  input  logic        pop_i,
  output word_t       dout_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [PW:0] level_o
);

  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   lvl_q, lvl_d;
  word_t         mem_q [DEPTH];
  logic          pop_en, push_en;

  assign empty_o = (lvl_q == '0);
  assign full_o  = (lvl_q == (PW+1)'(DEPTH));
  assign pop_en  = pop_i && !empty_o;
  assign push_en = push_i && (!full_o || pop_en);
  assign level_o = lvl_q;
  assign dout_o  = empty_o ? '0 : mem_q[rd_q];

  // Occupancy follows the net of accepted push and pop.
  always_comb begin
    lvl_d = lvl_q;
    if (push_en && !pop_en) lvl_d = lvl_q + (PW+1)'(1);
    else if (pop_en && !push_en) lvl_d = lvl_q - (PW+1)'(1);
  end

  // Pointers and level; pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      lvl_q <= lvl_d;
      if (push_en) wr_q <= wr_q + PW'(1);
      if (pop_en)  rd_q <= rd_q + PW'(1);
    end
  end

  // Storage array written at the tail.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_en) begin
      mem_q[wr_q] <= din_i;
    end
  end

endmodule

// File: rtl/rans_byte_packer.sv
// Packs encoder bytes little-endian into words,
// buffers them and flags drops on overflow.
module rans_byte_packer
  import rans_pkg::*;
#(
  parameter int SYMBOL_WIDTH = SYM_W,
  parameter int LANES        = NLANES,
  parameter int FIFO_DEPTH   = 8,
  localparam int CW = $clog2(LANES),
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          valid_i,
  input  logic [SYMBOL_WIDTH-1:0]       byte_i,
  input  logic                          flush_i,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [LANES*SYMBOL_WIDTH-1:0] m_data_o,
  output logic [LANES-1:0]              m_keep_o,
  output logic                          m_last_o,
  output logic [LW-1:0]                 level_o,
  output logic                          overflow_o
);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] asm_q, asm_d, fill;
  logic [CW:0]       n;
  logic              wrap, push, pop;
  logic              full, empty, ovf_q;
  word_t             pw, head;

  assign m_valid_o  = !empty;
  assign pop        = m_valid_o && m_ready_i;
  assign m_data_o   = head.data;
  assign m_keep_o   = head.keep;
  assign m_last_o   = head.last;
  assign overflow_o = ovf_q;

  // Lane insertion, word completion and flush.
  always_comb begin
    fill = asm_q;
    if (valid_i) fill[cnt_q*SYMBOL_WIDTH +: SYMBOL_WIDTH] = byte_i;
    n     = {1'b0, cnt_q} + {{CW{1'b0}}, valid_i};
    wrap  = (n == (CW+1)'(LANES));
    cnt_d = n[CW-1:0];
    asm_d = fill;
    push  = 1'b0;
    pw    = '0;
    for (int i = 0; i < LANES; i++) pw.keep[i] = (n > (CW+1)'(i));
    pw.data = fill;
    if (wrap || flush_i) begin
      push    = 1'b1;
      pw.last = flush_i;
      asm_d   = '0;
      cnt_d   = '0;
    end
  end

  // Assembly state and sticky overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      asm_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  rans_word_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .din_i  (pw),
    .pop_i  (pop),
    .dout_o (head),
    .full_o (full),
    .empty_o(empty),
    .level_o(level_o)
  );

endmodule

// File: tb/tb_rans_byte_packer.sv
// Randomized bench for rans_byte_packer with a
// queue-based reference model and directed cases.
module tb_rans_byte_packer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, flush, ready;
  logic [7:0]  byt;
  logic        m_valid, m_last, ovf;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic [3:0]  level;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } mw_t;

  mw_t        q[$];
  logic [7:0] abuf[$];
  bit         mov;

  rans_byte_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .valid_i   (valid),
    .byte_i    (byt),
    .flush_i   (flush),
    .m_valid_o (m_valid),
    .m_ready_i (ready),
    .m_data_o  (m_data),
    .m_keep_o  (m_keep),
    .m_last_o  (m_last),
    .level_o   (level),
    .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: bytes gather in a list; 4 bytes or a flush
  // emit a word; queue holds buffered words.
  task automatic model(bit v, logic [7:0] b, bit f, bit r);
    int  sz0 = q.size();
    bit  pp  = (sz0 > 0) && r;
    mw_t w;
    if (pp) q.delete(0);
    if (v) abuf.push_back(b);
    if (abuf.size() == 4 || f) begin
      w.d = '0;
      for (int j = 0; j < abuf.size(); j++) w.d[8*j +: 8] = abuf[j];
      w.k = 4'((1 << abuf.size()) - 1);
      w.l = f;
      if (sz0 == DEPTH && !pp) mov = 1'b1;
      else q.push_back(w);
      abuf.delete();
    end
  endtask

  task automatic cyc(bit v, logic [7:0] b, bit f, bit r);
    valid = v; byt = b; flush = f; ready = r;
    @(posedge clk);
    model(v, b, f, r);
    #1;
  endtask

  task automatic do_reset();
    valid = 0; byt = 0; flush = 0; ready = 0;
    #2 rst_n = 1'b0;
    q.delete(); abuf.delete(); mov = 1'b0;
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_payload", {m_data, m_keep, m_last}, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", m_valid, q.size() != 0);
      chk("level", level, q.size());
      chk("overflow", ovf, mov);
      if (q.size() != 0) begin
        chk("data", m_data, q[0].d);
        chk("keep", m_keep, q[0].k);
        chk("last", m_last, q[0].l);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    do_reset();

    for (int i = 1; i <= 8; i++) begin
      cyc(1, 8'(i), 0, 1);
      if (i == 3) chk("lat_pre", m_valid, 0);
      if (i == 4) begin
        chk("lat_valid", m_valid, 1);
        chk("w0", {m_data, m_keep, m_last}, {32'h04030201, 4'hf, 1'b0});
      end
      if (i == 8) chk("w1", {m_data, m_keep, m_last}, {32'h08070605, 4'hf, 1'b0});
    end
    cyc(0, 0, 0, 1);

    cyc(1, 8'hAA, 0, 0);
    cyc(1, 8'hBB, 0, 0);
    cyc(1, 8'hCC, 0, 0);
    cyc(0, 0, 1, 0);
    chk("partial", {m_data, m_keep, m_last}, {32'h00CCBBAA, 4'h7, 1'b1});
    chk("model_partial", q[0].d, 32'h00CCBBAA);
    cyc(0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) cyc(1, 8'(i), 0, 0);
    chk("lane0", m_data, 32'h04030201);
    cyc(0, 0, 0, 1);

    cyc(1, 8'h11, 0, 0);
    cyc(1, 8'h22, 0, 0);
    cyc(1, 8'h33, 0, 0);
    cyc(1, 8'h44, 1, 0);
    chk("fl_full", {m_data, m_keep, m_last}, {32'h44332211, 4'hf, 1'b1});
    cyc(0, 0, 0, 0);
    chk("no_marker", level, 1);
    cyc(0, 0, 0, 1);

    for (int k = 0; k < 36; k++) begin
      cyc(1, 8'(k), 0, 0);
      if (k == 31) chk("full_lvl", level, 8);
      if (k == 34) chk("ovf_pre", ovf, 0);
      if (k == 35) chk("ovf_set", ovf, 1);
    end
    chk("drain_head", m_data, 32'h03020100);
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 1);
    chk("drained", level, 0);
    chk("ovf_sticky", ovf, 1);

    do_reset();
    for (int k = 0; k < 35; k++) cyc(1, 8'(k), 0, 0);
    cyc(1, 8'd35, 0, 1);
    chk("full_pp_lvl", level, 8);
    chk("full_pp_ovf", ovf, 0);
    for (int k = 0; k < 7; k++) cyc(0, 0, 0, 1);
    chk("tail_word", m_data, 32'h23222120);
    cyc(0, 0, 0, 1);

    for (int k = 0; k < 14; k++) cyc(1, 8'(k + 5), 0, 0);
    chk("pre_rst_lvl", level, 3);
    do_reset();
    cyc(0, 0, 1, 0);
    chk("marker", {m_valid, m_data, m_keep, m_last}, {1'b1, 32'h0, 4'h0, 1'b1});
    cyc(0, 0, 0, 1);

    for (int k = 0; k < 800; k++) begin
      cyc($urandom_range(0, 9) < 7, 8'($urandom),
          $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 4);
    end
    for (int k = 0; k < 10; k++) cyc(0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
